rtc_bcd_counter_chain: RTL and testbench
========================================

RTC_BCD_COUNTER_CHAIN -- requirements
Module: rtc_bcd_counter_chain

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of cascaded BCD digits, legal range 1..8.
REQ-002 Parameter ROLLOVER_VEC, default 24'h595999, per-digit maximum value (4 bits per digit, digit 0 in bits [3:0]), each nibble 1..9.
REQ-003 i_rtcclk  input  1  sole clock, mapped to the 10 ms basetick; all logic on rising edge.
REQ-004 i_reset_n  input  1  reset, synchronous and active-low.
REQ-005 i_countenb  input  1  count enable.
REQ-006 i_latchcount  input  1  count qualifier from the trigger block; step = i_countenb & i_latchcount.
REQ-007 i_countinit  input  1  synchronous clear of all digits.
REQ-008 i_dir  input  1  count direction, 0 = up, 1 = down.
REQ-009 i_load  input  1  parallel load strobe.
REQ-010 i_loaddata  input  4*NUM_DIGITS  BCD value to load.
REQ-011 o_bcdcount  output  4*NUM_DIGITS  registered BCD count, digit 0 in bits [3:0].
REQ-012 o_rolloverflag  output  NUM_DIGITS  registered per-digit wrap pulse.
REQ-013 o_wrap  output  1  registered pulse: entire chain wrapped.

Function
REQ-014 Priority per edge SHALL be reset > i_countinit > i_load > step > hold.
REQ-015 i_countinit SHALL set all digits to 0 and clear all flags on the same edge.
REQ-016 i_load SHALL load each digit from i_loaddata, clamping any nibble above its ROLLOVER_VEC nibble to that maximum; flags cleared.
REQ-017 Up step: digit k SHALL advance iff step and every lower digit equals its maximum; digit at maximum SHALL go to 0, otherwise +1.
REQ-018 Down step: digit k SHALL advance iff step and every lower digit equals 0; digit at 0 SHALL go to its maximum, otherwise -1.
REQ-019 All digits SHALL update on the same edge (lookahead carry, no ripple latency); count latency one cycle from qualified step.
REQ-020 o_rolloverflag[k] SHALL be 1 for exactly the cycle after digit k wrapped and 0 in every other cycle, including hold cycles.
REQ-021 o_wrap SHALL equal o_rolloverflag[NUM_DIGITS-1] AND all lower flags (full-chain wrap: 0 after max for up, max after 0 for down).
REQ-022 Without step, digits SHALL hold; i_dir changes while not stepping SHALL have no effect.
REQ-023 A digit value above its maximum (unreachable) SHALL be treated as maximum by the next step.

Reset
REQ-024 On i_rtcclk edge with i_reset_n = 0: o_bcdcount = 0, o_rolloverflag = 0, o_wrap = 0, regardless of other inputs.
REQ-025 Reset asserted mid-count SHALL discard the pending step; first step after release counts from 0.

Configuration
REQ-026 Macro RTC_BCDCHAIN_DOWN_EN defined: i_dir honoured per REQ-018.
REQ-027 Macro RTC_BCDCHAIN_DOWN_EN undefined: down logic SHALL be absent, i_dir ignored, chain counts up only.

Structure
REQ-028 Package rtc_pkg SHALL hold typedef bcd_digit_t (4-bit), constant RTC_MAX_DIGITS = 8, and default ROLLOVER constant 24'h595999.
REQ-029 One sub-module rtc_bcd_digit SHALL implement a single digit (inputs: advance, dir, clear, load, max; outputs: value, wrap, at_max, at_zero), instantiated NUM_DIGITS times via generate.

Verification (NUM_DIGITS=6, ROLLOVER_VEC=24'h595999)
REQ-030 Reset: i_reset_n=0 one edge with step=1, load=1 -> o_bcdcount=24'h000000, flags 0.
REQ-031 Up: load 24'h000999, one step -> 24'h001000, o_rolloverflag=6'b000111 for one cycle, o_wrap=0.
REQ-032 Full wrap: load 24'h595999, one up step -> 24'h000000, o_rolloverflag=6'b111111, o_wrap=1 for one cycle, then 0.
REQ-033 Down: macro defined, count 24'h000000, i_dir=1 step -> 24'h595999, o_wrap=1; macro undefined same stimulus -> 24'h000001, o_wrap=0.
REQ-034 Clamp: load 24'h7A0F00 -> 24'h590900.
REQ-035 Simultaneous: count 24'h123456, i_countinit=1, i_load=1, step=1 same edge -> 24'h000000, flags 0; i_countenb=1, i_latchcount=0 ten cycles -> count unchanged.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC BCD counter chain.
package rtc_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam int          RTC_MAX_DIGITS       = 8;
   localparam logic [23:0] RTC_ROLLOVER_DEFAULT = 24'h595999;

   // Limit a loaded nibble to the digit's maximum.
   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t v, input bcd_digit_t max);
      return (v > max) ? max : v;
   endfunction

endpackage

// File: rtl/rtc_bcd_digit.sv
// One BCD digit of the RTC chain: clear/load/advance with a registered wrap pulse.
// Down counting is compiled in only when RTC_BCDCHAIN_DOWN_EN is defined.
module rtc_bcd_digit
   import rtc_pkg::*;
(
   input  logic       i_rtcclk,
   input  logic       i_reset_n,
   input  logic       advance,
   input  logic       dir,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic [3:0] max,
   output logic [3:0] value,
   output logic       wrap,
   output logic       at_max,
   output logic       at_zero
);

   bcd_digit_t nxt_val;
   logic       nxt_wrap;

   // A value above max can only come from corruption; it behaves as max.
   assign at_max  = (value >= max);
   assign at_zero = (value == 4'd0);

   always_comb begin
      nxt_val  = at_max ? 4'd0 : value + 4'd1;
      nxt_wrap = at_max;
`ifdef RTC_BCDCHAIN_DOWN_EN
      if (dir) begin
         nxt_val  = at_zero ? max : (at_max ? max - 4'd1 : value - 4'd1);
         nxt_wrap = at_zero;
      end
`endif
   end

`ifndef RTC_BCDCHAIN_DOWN_EN
   logic dir_unused;
   assign dir_unused = dir;
`endif

   always_ff @(posedge i_rtcclk) begin
      if (!i_reset_n) begin
         value <= 4'd0;
         wrap  <= 1'b0;
      end else if (clear) begin
         value <= 4'd0;
         wrap  <= 1'b0;
      end else if (load) begin
         value <= bcd_clamp(load_val, max);
         wrap  <= 1'b0;
      end else if (advance) begin
         value <= nxt_val;
         wrap  <= nxt_wrap;
      end else begin
         wrap  <= 1'b0;
      end
   end

endmodule

// File: rtl/rtc_bcd_counter_chain.sv
// Cascaded BCD counter chain with lookahead carry so every digit updates on the same edge.
// Define RTC_BCDCHAIN_DOWN_EN to enable down counting via i_dir.
module rtc_bcd_counter_chain
   import rtc_pkg::*;
#(
   parameter int                      NUM_DIGITS   = 6,
   parameter logic [4*NUM_DIGITS-1:0] ROLLOVER_VEC = RTC_ROLLOVER_DEFAULT
) (
   input  logic                      i_rtcclk,
   input  logic                      i_reset_n,
   input  logic                      i_countenb,
   input  logic                      i_latchcount,
   input  logic                      i_countinit,
   input  logic                      i_dir,
   input  logic                      i_load,
   input  logic [4*NUM_DIGITS-1:0]   i_loaddata,
   output logic [4*NUM_DIGITS-1:0]   o_bcdcount,
   output logic [NUM_DIGITS-1:0]     o_rolloverflag,
   output logic                      o_wrap
);

   logic                  step;
   logic                  digit_dir;
   logic [NUM_DIGITS:0]   carry;
   logic [NUM_DIGITS-1:0] at_max;
   logic [NUM_DIGITS-1:0] at_zero;

   assign step     = i_countenb & i_latchcount;
   assign carry[0] = step;

`ifdef RTC_BCDCHAIN_DOWN_EN
   assign digit_dir = i_dir;
`else
   logic dir_unused;
   assign digit_dir  = 1'b0;
   assign dir_unused = i_dir ^ (^at_zero);
`endif

   genvar k;
   generate
      for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
         // carry[k] is high when step is set and every lower digit sits at its limit.
`ifdef RTC_BCDCHAIN_DOWN_EN
         assign carry[k+1] = carry[k] & (i_dir ? at_zero[k] : at_max[k]);
`else
         assign carry[k+1] = carry[k] & at_max[k];
`endif
         rtc_bcd_digit u_digit (
            .i_rtcclk  (i_rtcclk),
            .i_reset_n (i_reset_n),
            .advance   (carry[k]),
            .dir       (digit_dir),
            .clear     (i_countinit),
            .load      (i_load),
            .load_val  (i_loaddata[4*k +: 4]),
            .max       (ROLLOVER_VEC[4*k +: 4]),
            .value     (o_bcdcount[4*k +: 4]),
            .wrap      (o_rolloverflag[k]),
            .at_max    (at_max[k]),
            .at_zero   (at_zero[k])
         );
      end
   endgenerate

   // Carry out of the top digit means every digit wraps on this edge.
   always_ff @(posedge i_rtcclk) begin
      if (!i_reset_n)
         o_wrap <= 1'b0;
      else if (i_countinit || i_load)
         o_wrap <= 1'b0;
      else
         o_wrap <= carry[NUM_DIGITS];
   end

endmodule

// File: tb/tb_rtc_bcd_counter_chain.sv
// Directed self-checking bench for rtc_bcd_counter_chain (NUM_DIGITS=6, ROLLOVER 595999).
module tb_rtc_bcd_counter_chain;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        countenb;
   logic        latchcount;
   logic        countinit;
   logic        dir;
   logic        load;
   logic [23:0] loaddata;
   logic [23:0] bcdcount;
   logic [5:0]  rolloverflag;
   logic        wrap;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   rtc_bcd_counter_chain #(
      .NUM_DIGITS   (6),
      .ROLLOVER_VEC (24'h595999)
   ) dut (
      .i_rtcclk       (clk),
      .i_reset_n      (reset_n),
      .i_countenb     (countenb),
      .i_latchcount   (latchcount),
      .i_countinit    (countinit),
      .i_dir          (dir),
      .i_load         (load),
      .i_loaddata     (loaddata),
      .o_bcdcount     (bcdcount),
      .o_rolloverflag (rolloverflag),
      .o_wrap         (wrap)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag, input logic [23:0] c, input logic [5:0] f, input logic w);
      check({tag, "_count"}, {8'h0, bcdcount}, {8'h0, c});
      check({tag, "_flags"}, {26'h0, rolloverflag}, {26'h0, f});
      check({tag, "_wrap"}, {31'h0, wrap}, {31'h0, w});
   endtask

   task automatic do_load(input logic [23:0] v);
      load = 1'b1; loaddata = v;
      tick();
      load = 1'b0;
   endtask

   initial begin
      reset_n = 1'b1; countenb = 1'b0; latchcount = 1'b0; countinit = 1'b0;
      dir = 1'b0; load = 1'b0; loaddata = 24'h0;

      // Reset wins over load and step
      reset_n = 1'b0; countenb = 1'b1; latchcount = 1'b1; load = 1'b1; loaddata = 24'h123456;
      tick();
      check_all("reset", 24'h000000, 6'b000000, 1'b0);
      reset_n = 1'b1; countenb = 1'b0; latchcount = 1'b0; load = 1'b0;

      // Up step with partial carry
      do_load(24'h000999);
      check_all("load999", 24'h000999, 6'b000000, 1'b0);
      countenb = 1'b1; latchcount = 1'b1;
      tick();
      check_all("up999", 24'h001000, 6'b000111, 1'b0);
      countenb = 1'b0;
      tick();
      check_all("hold1000", 24'h001000, 6'b000000, 1'b0);

      // Full chain wrap
      do_load(24'h595999);
      countenb = 1'b1;
      tick();
      check_all("fullwrap", 24'h000000, 6'b111111, 1'b1);
      countenb = 1'b0;
      tick();
      check_all("afterwrap", 24'h000000, 6'b000000, 1'b0);

      // Down direction (or ignored direction when down logic is absent)
      dir = 1'b1; countenb = 1'b1;
      tick();
`ifdef RTC_BCDCHAIN_DOWN_EN
      check_all("down0", 24'h595999, 6'b111111, 1'b1);
`else
      check_all("down0", 24'h000001, 6'b000000, 1'b0);
`endif
      countenb = 1'b0;
      do_load(24'h001000);
      countenb = 1'b1;
      tick();
`ifdef RTC_BCDCHAIN_DOWN_EN
      check_all("down1000", 24'h000999, 6'b000111, 1'b0);
`else
      check_all("down1000", 24'h001001, 6'b000000, 1'b0);
`endif
      countenb = 1'b0; dir = 1'b0;

      // Clamp on load, then count from the clamped value
      do_load(24'h7A0F00);
      check_all("clamp", 24'h590900, 6'b000000, 1'b0);
      countenb = 1'b1;
      tick();
      check_all("clampstep", 24'h590901, 6'b000000, 1'b0);
      countenb = 1'b0;

      // Digit 0 wrap alone
      do_load(24'h000008);
      countenb = 1'b1;
      tick();
      check_all("step8", 24'h000009, 6'b000000, 1'b0);
      tick();
      check_all("step9", 24'h000010, 6'b000001, 1'b0);
      countenb = 1'b0;

      // Clear beats load beats step
      do_load(24'h123456);
      check_all("load123456", 24'h123456, 6'b000000, 1'b0);
      countinit = 1'b1; load = 1'b1; loaddata = 24'h595999; countenb = 1'b1;
      tick();
      check_all("initprio", 24'h000000, 6'b000000, 1'b0);
      countinit = 1'b0; loaddata = 24'h000999;
      tick();
      check_all("loadprio", 24'h000999, 6'b000000, 1'b0);
      load = 1'b0;

      // Step unqualified: hold for ten cycles while dir toggles
      latchcount = 1'b0; countenb = 1'b1;
      for (int i = 0; i < 10; i++) begin
         dir = ~dir;
         tick();
      end
      check_all("nolatch", 24'h000999, 6'b000000, 1'b0);
      countenb = 1'b0; latchcount = 1'b1; dir = 1'b0;
      tick();
      check_all("noenb", 24'h000999, 6'b000000, 1'b0);

      // Reset mid-count discards the step; counting resumes from zero
      countenb = 1'b1; reset_n = 1'b0;
      tick();
      check_all("midreset", 24'h000000, 6'b000000, 1'b0);
      reset_n = 1'b1;
      tick();
      check_all("postreset1", 24'h000001, 6'b000000, 1'b0);
      tick();
      tick();
      check_all("postreset3", 24'h000003, 6'b000000, 1'b0);
      countenb = 1'b0; latchcount = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
